// File: rtl/aes_v2_lanes.sv
// aes_v2_lanes: lane-parallel AES v2 SubBytes / MixColumn unit.
//
// LANES output bytes are produced per cycle, so one instruction takes
// STEPS = 4/LANES compute cycles. The result is presented on rd together
// with a single-cycle ready pulse.
//
// Ports:
//   g_clk     clock
//   g_resetn  asynchronous active-low reset
//   valid     request, held with stable operands until ready
//   sub       1 = SubBytes, 0 = MixColumn
//   enc       1 = forward, 0 = inverse
//   rs1, rs2  source operands (bytes m0..m3 are gathered from both)
//   ready     one-cycle pulse, rd valid in this cycle
//   rd        registered 32-bit result
//   busy      high while the FSM is in BUSY
//
// Also contains aes_sbox, the forward/inverse AES S-box used per lane.

// aes_sbox: combinational AES S-box.
//   a    input byte
//   inv  0 = forward S, 1 = inverse S
//   s    substituted byte
module aes_sbox (
  input  logic [7:0] a,
  input  logic       inv,
  output logic [7:0] s
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  logic [7:0] t;

  // Forward: affine(inverse(a)). Inverse: inverse(inverse_affine(a)).
  always_comb begin
    t = 8'h00;
    s = 8'h00;
    if (!inv) begin
      t = gf_inv(a);
      s = t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
    end else begin
      t = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
      s = gf_inv(t);
    end
  end

endmodule

module aes_v2_lanes #(
  parameter int LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        sub,
  input  logic        enc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic [31:0] rd,
  output logic        busy
);

  localparam int         STEPS     = 4 / LANES;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("aes_v2_lanes: LANES must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] step;
  logic       last_step;
  logic       do_step;
  logic [7:0] m [4];
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [2*LANES-1:0] lane_idx;
  logic [8*LANES-1:0] lane_out;

  // Only half of each source register carries operand bytes.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{rs1[15:8], rs1[31:24], rs2[7:0], rs2[23:16]};

  assign m[0] = rs1[7:0];
  assign m[1] = rs2[15:8];
  assign m[2] = rs1[23:16];
  assign m[3] = rs2[31:24];

  // step is 0 whenever the FSM is IDLE, so it is also the step index for
  // the first compute cycle.
  assign last_step = (step == LAST_STEP);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid) state_next = last_step ? DONE : BUSY;
      BUSY: begin
        if (!valid)         state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A valid seen in DONE still belongs to the finishing instruction, so
  // only IDLE and BUSY consume it.
  always_comb begin
    ready   = (state == DONE);
    busy    = (state == BUSY);
    do_step = valid && (state == IDLE || state == BUSY);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn)                    step <= 2'd0;
    else if (state == BUSY && !valid) step <= 2'd0;
    else if (do_step)                 step <= last_step ? 2'd0 : step + 2'd1;
  end

  // Lane j handles output byte step*LANES+j; the mod-4 wrap of the 2-bit
  // index also gives the rotated neighbours m(i+1..i+3).
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [1:0] idx;
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] sbox_out, mix_fwd, mix_inv;
    logic [7:0] a0_2, a0_4, a0_8, a1_2, a1_4, a1_8, a2_2, a2_4, a2_8, a3_2, a3_4, a3_8;

    assign idx = 2'(int'(step) * LANES + j);
    assign a0  = m[idx];
    assign a1  = m[idx + 2'd1];
    assign a2  = m[idx + 2'd2];
    assign a3  = m[idx + 2'd3];

    aes_sbox u_sbox (.a(a0), .inv(!enc), .s(sbox_out));

    assign a0_2 = xt(a0);  assign a0_4 = xt(a0_2);  assign a0_8 = xt(a0_4);
    assign a1_2 = xt(a1);  assign a1_4 = xt(a1_2);  assign a1_8 = xt(a1_4);
    assign a2_2 = xt(a2);  assign a2_4 = xt(a2_2);  assign a2_8 = xt(a2_4);
    assign a3_2 = xt(a3);  assign a3_4 = xt(a3_2);  assign a3_8 = xt(a3_4);

    assign mix_fwd = a0_2 ^ (a1_2 ^ a1) ^ a2 ^ a3;
    assign mix_inv = (a0_8 ^ a0_4 ^ a0_2) ^ (a1_8 ^ a1_2 ^ a1)
                   ^ (a2_8 ^ a2_4 ^ a2)   ^ (a3_8 ^ a3);

    assign lane_idx[2*j +: 2] = idx;
    assign lane_out[8*j +: 8] = sub ? sbox_out : (enc ? mix_fwd : mix_inv);
  end

  always_comb begin
    acc_next = acc;
    for (int j = 0; j < LANES; j++) begin
      acc_next[{lane_idx[2*j +: 2], 3'b000} +: 8] = lane_out[8*j +: 8];
    end
  end

  // Partial bytes collect in acc; rd only takes the finished word, so an
  // aborted instruction leaves rd untouched.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      acc <= 32'h0;
      rd  <= 32'h0;
    end else if (do_step) begin
      acc <= acc_next;
      if (last_step) rd <= acc_next;
    end
  end

endmodule

// File: tb/tb_aes_v2_lanes.sv
// tb_aes_v2_lanes: self-checking bench for aes_v2_lanes.
// Three instances (LANES = 1, 2, 4) share clock and reset but have their
// own request inputs. Index d selects an instance: LANES = 1<<d,
// STEPS = 4>>d.
module tb_aes_v2_lanes;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        valid_a [3];
  logic        sub_a   [3];
  logic        enc_a   [3];
  logic [31:0] rs1_a   [3];
  logic [31:0] rs2_a   [3];
  logic        ready_a [3];
  logic [31:0] rd_a    [3];
  logic        busy_a  [3];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 g_clk = ~g_clk;

  aes_v2_lanes #(.LANES(1)) dut_l1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[0]), .sub(sub_a[0]),
    .enc(enc_a[0]), .rs1(rs1_a[0]), .rs2(rs2_a[0]), .ready(ready_a[0]),
    .rd(rd_a[0]), .busy(busy_a[0]));

  aes_v2_lanes #(.LANES(2)) dut_l2 (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[1]), .sub(sub_a[1]),
    .enc(enc_a[1]), .rs1(rs1_a[1]), .rs2(rs2_a[1]), .ready(ready_a[1]),
    .rd(rd_a[1]), .busy(busy_a[1]));

  aes_v2_lanes #(.LANES(4)) dut_l4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[2]), .sub(sub_a[2]),
    .enc(enc_a[2]), .rs1(rs1_a[2]), .rs2(rs2_a[2]), .ready(ready_a[2]),
    .rd(rd_a[2]), .busy(busy_a[2]));

  // Reference AES S-box, row by row from the standard table.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [7:0] sbox_t     [256];
  logic [7:0] inv_sbox_t [256];

  typedef struct {
    int          dut;
    logic        sub;
    logic        enc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [11];

  // Operands must not move while an instance is busy.
  logic [65:0] held [3];
  always @(posedge g_clk) begin
    for (int d = 0; d < 3; d++) begin
      if (busy_a[d])
        assert ({sub_a[d], enc_a[d], rs1_a[d], rs2_a[d]} == held[d])
          else $error("[TB] operands changed while busy, instance %0d", d);
      held[d] <= {sub_a[d], enc_a[d], rs1_a[d], rs2_a[d]};
    end
  end

  // Shift-and-reduce GF(2^8) multiply, used by the golden model.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Golden model of the full instruction result.
  function automatic logic [31:0] golden(input logic s, input logic e,
                                         input logic [31:0] r1, input logic [31:0] r2);
    logic [7:0]  m [4];
    logic [31:0] res;
    m[0] = r1[7:0]; m[1] = r2[15:8]; m[2] = r1[23:16]; m[3] = r2[31:24];
    res = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (s)
        res[8*i +: 8] = e ? sbox_t[m[i]] : inv_sbox_t[m[i]];
      else if (e)
        res[8*i +: 8] = gmul(8'h02, m[i]) ^ gmul(8'h03, m[(i+1)%4])
                      ^ m[(i+2)%4] ^ m[(i+3)%4];
      else
        res[8*i +: 8] = gmul(8'h0e, m[i]) ^ gmul(8'h0b, m[(i+1)%4])
                      ^ gmul(8'h0d, m[(i+2)%4]) ^ gmul(8'h09, m[(i+3)%4]);
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete instruction on instance d: checks it starts idle, that
  // busy/ready follow the STEPS-cycle schedule, and the final rd.
  task automatic applyStimulus(input int d, input logic s, input logic e,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] exp_rd);
    int steps;
    steps = 4 >> d;
    @(posedge g_clk); #1;
    checkOutput($sformatf("L%0d idle ready", 1 << d), 32'(ready_a[d]), 32'd0);
    checkOutput($sformatf("L%0d idle busy", 1 << d), 32'(busy_a[d]), 32'd0);
    valid_a[d] = 1'b1; sub_a[d] = s; enc_a[d] = e; rs1_a[d] = r1; rs2_a[d] = r2;
    for (int c = 1; c <= steps; c++) begin
      @(posedge g_clk); #1;
      checkOutput($sformatf("L%0d busy cycle %0d", 1 << d, c), 32'(busy_a[d]), 32'(c < steps));
      checkOutput($sformatf("L%0d ready cycle %0d", 1 << d, c), 32'(ready_a[d]), 32'(c == steps));
    end
    checkOutput($sformatf("L%0d rd", 1 << d), rd_a[d], exp_rd);
    valid_a[d] = 1'b0;
  endtask

  task automatic randomRun(input int d, input int n);
    logic [31:0] r1, r2;
    logic        s, e;
    for (int k = 0; k < n; k++) begin
      r1 = $urandom; r2 = $urandom;
      s  = 1'($urandom_range(0, 1));
      e  = 1'($urandom_range(0, 1));
      applyStimulus(d, s, e, r1, r2, golden(s, e, r1, r2));
    end
  endtask

  initial begin
    logic [2047:0] rom;
    rom = SBOX_ROM;
    for (int i = 0; i < 256; i++) begin
      sbox_t[i] = rom[2047 - 8*i -: 8];
      inv_sbox_t[sbox_t[i]] = 8'(i);
    end

    // Directed vectors: {instance, sub, enc, rs1, rs2, expected rd}.
    vecs[0]  = '{2, 1'b1, 1'b1, 32'h00530001, 32'hff000000, 32'h16ed637c};
    vecs[1]  = '{0, 1'b0, 1'b1, 32'h005300db, 32'h45001300, 32'hbca14d8e};
    vecs[2]  = '{1, 1'b0, 1'b0, 32'h00a1008e, 32'hbc004d00, 32'h455313db};
    vecs[3]  = '{1, 1'b1, 1'b0, 32'h00ed007c, 32'h16006300, 32'hff530001};
    vecs[4]  = '{2, 1'b0, 1'b1, 32'h002200f2, 32'h5c000a00, 32'h9d58dc9f};
    vecs[5]  = '{0, 1'b0, 1'b1, 32'h00d400d4, 32'hd500d400, 32'hd6d7d5d5};
    vecs[6]  = '{0, 1'b1, 1'b0, 32'h00ed007c, 32'h16006300, 32'hff530001};
    vecs[7]  = '{2, 1'b0, 1'b0, 32'h00a1008e, 32'hbc004d00, 32'h455313db};
    vecs[8]  = '{1, 1'b1, 1'b1, 32'h00530001, 32'hff000000, 32'h16ed637c};
    vecs[9]  = '{2, 1'b1, 1'b1, 32'haa53bb01, 32'hffcc00dd, 32'h16ed637c};
    vecs[10] = '{0, 1'b0, 1'b0, 32'h0058009f, 32'h9d00dc00, 32'h5c220af2};

    g_resetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      valid_a[d] = 1'b0; sub_a[d] = 1'b0; enc_a[d] = 1'b0;
      rs1_a[d] = 32'h0; rs2_a[d] = 32'h0;
    end

    // Reset state of every instance.
    #12;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("L%0d reset rd", 1 << d), rd_a[d], 32'h0);
      checkOutput($sformatf("L%0d reset ready", 1 << d), 32'(ready_a[d]), 32'd0);
      checkOutput($sformatf("L%0d reset busy", 1 << d), 32'(busy_a[d]), 32'd0);
    end
    #5 g_resetn = 1'b1;

    // Table of directed vectors; consecutive entries on one instance run
    // back to back, the second request arriving the cycle after ready.
    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].dut, vecs[i].sub, vecs[i].enc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);

    // Abort on LANES=1: valid held for two cycles then dropped. rd must keep
    // the previous result (0x5c220af2) and no ready may appear.
    @(posedge g_clk); #1;
    valid_a[0] = 1'b1; sub_a[0] = 1'b1; enc_a[0] = 1'b1;
    rs1_a[0] = 32'h00530001; rs2_a[0] = 32'hff000000;
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    checkOutput("abort busy before drop", 32'(busy_a[0]), 32'd1);
    valid_a[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge g_clk); #1;
      checkOutput("abort busy", 32'(busy_a[0]), 32'd0);
      checkOutput("abort ready", 32'(ready_a[0]), 32'd0);
      checkOutput("abort rd kept", rd_a[0], 32'h5c220af2);
    end
    applyStimulus(0, 1'b0, 1'b1, 32'h005300db, 32'h45001300, 32'hbca14d8e);

    // Asynchronous reset mid-operation on LANES=1, asserted between edges.
    @(posedge g_clk); #1;
    valid_a[0] = 1'b1; sub_a[0] = 1'b0; enc_a[0] = 1'b0;
    rs1_a[0] = 32'h00a1008e; rs2_a[0] = 32'hbc004d00;
    @(posedge g_clk);
    @(posedge g_clk); #3;
    checkOutput("pre-reset busy", 32'(busy_a[0]), 32'd1);
    g_resetn = 1'b0;
    valid_a[0] = 1'b0;
    #1;
    checkOutput("async reset rd", rd_a[0], 32'h0);
    checkOutput("async reset ready", 32'(ready_a[0]), 32'd0);
    checkOutput("async reset busy", 32'(busy_a[0]), 32'd0);
    #3 g_resetn = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 32'h00a1008e, 32'hbc004d00, 32'h455313db);

    // Random operands on all three instances in parallel against the model.
    fork
      randomRun(0, 3334);
      randomRun(1, 3333);
      randomRun(2, 3333);
    join

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aes_v2_lanes.md
Name: aes_v2_lanes

Overview:
- Parametrised successor to the single-cycle AES v2 SubBytes/MixColumn unit; implements the same two instructions with a configurable number of byte lanes.
- LANES bytes of the 32-bit result are computed per cycle, trading area (SBox and mix-column instances) against latency.
- The result is registered. The block sits beside the integer ALU and is driven by the CPU execute stage through a valid/ready handshake.

Parameters:
- LANES, 1, output bytes computed per cycle; legal values 1, 2, 4. Any other value is an elaboration error.
- STEPS, 4/LANES, derived localparam; number of compute cycles per instruction.

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- valid  in  1  request; held high, with all operands stable, until ready
- sub  in  1  1 = SubBytes, 0 = MixColumn
- enc  in  1  1 = forward (encrypt), 0 = inverse (decrypt)
- rs1  in  32  source register 1
- rs2  in  32  source register 2
- ready  out  1  single-cycle pulse; rd is valid in this cycle
- rd  out  32  result
- busy  out  1  high while the FSM is in BUSY

Behaviour:
- Reset values: ready=0, rd=0, busy=0, FSM in IDLE, step counter=0. Reset takes effect immediately on assertion, including mid-operation; any partial result is discarded.
- Operand bytes:
  - m0 = rs1[7:0]
  - m1 = rs2[15:8]
  - m2 = rs1[23:16]
  - m3 = rs2[31:24]
  - Output byte i goes to rd[8i+7:8i].
- SubBytes: out_i = S(m_i) when enc=1, InvS(m_i) when enc=0. Uses LANES instances of the existing aes_sbox, driven with inv = !enc.
- MixColumn forward: out_i = 2·m_i ^ 3·m_(i+1) ^ m_(i+2) ^ m_(i+3).
- MixColumn inverse: out_i = 0e·m_i ^ 0b·m_(i+1) ^ 0d·m_(i+2) ^ 09·m_(i+3).
- Byte indices are mod 4. All multiplication is in GF(2^8) modulo 0x11b, built from xtime.
- Lane mapping: in step k (0..STEPS-1), lane j computes output byte k·LANES+j. The lane input multiplexers select m by that index.
- FSM states and transitions:
  - IDLE: on valid=1, compute step 0, store it, counter←1. Next state is BUSY, or DONE if STEPS=1.
  - BUSY: if valid=1, compute step=counter, store it, counter++. After the last step, go to DONE. If valid=0, abort: go to IDLE, counter←0, no ready pulse, rd keeps its previous value.
  - DONE: ready=1, rd = full result register, go to IDLE. A valid still high in this cycle is ignored (it belongs to the completing instruction).
- Latency: ready is asserted exactly STEPS cycles after the first cycle valid is high.
  - LANES=4: 1 cycle; LANES=2: 2 cycles; LANES=1: 4 cycles.
- Throughput: one instruction per STEPS+1 cycles. A new request may be presented in the cycle after ready.
- rd holds its value between instructions. Result bytes not yet written by the current instruction are not guaranteed until ready.
- A change of sub, enc, rs1 or rs2 while busy is illegal. Behaviour is undefined; the bench asserts against it.
- busy = (state==BUSY).

Test Plan:
1. LANES=4, sub=1, enc=1, rs1=0x00530001, rs2=0xff000000 -> ready one cycle after valid, rd=0x16ed637c.
2. LANES=1, sub=0, enc=1, rs1=0x005300db, rs2=0x45001300 -> ready 4 cycles after valid, exactly one pulse, rd=0xbca14d8e. busy is high for cycles 1-3.
3. LANES=2, sub=0, enc=0, rs1=0x00a1008e, rs2=0xbc004d00 -> ready after 2 cycles, rd=0x455313db. Then sub=1, enc=0, rs1=0x00ed007c, rs2=0x16006300 presented the next cycle -> rd=0xff530001.
4. LANES=1, valid dropped after 2 cycles -> no ready, FSM returns to IDLE, rd unchanged. A following request completes normally with the correct result.
5. LANES=1, g_resetn pulsed low mid-operation (asynchronously, between clock edges) -> rd=0, ready=0 and busy=0 immediately. After release the FSM is in IDLE and a new request completes in 4 cycles.
6. All LANES values, 10k random operands, checked against a golden AES model -> results identical, ready latency exactly STEPS in every case.
